// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze sequencer sitting around the time comparator.
// Optional feature macro: BUZZER_BEEP_EN (0.5 Hz beep in RING instead of a steady tone).
module alarm_ring_ctrl #(
   parameter int unsigned DAY_SEC          = 86400,
   parameter int unsigned SNOOZE_SEC       = 300,
   parameter int unsigned RING_TIMEOUT_SEC = 60,
   parameter int unsigned MAX_SNOOZE       = 3
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        TICK_1HZ,
   input  logic        ALARM_ENABLE,
   input  logic [16:0] ALARM_TIME,
   input  logic [16:0] CURRENT_TIME,
   input  logic        MATCH,
   input  logic        STOP,
   input  logic        SNOOZE,
   output logic [16:0] COMPARE_TIME,
   output logic        COMPARE_EN,
   output logic        BUZZER,
   output logic [1:0]  RING_STATE,
   output logic [1:0]  SNOOZE_CNT
);

   localparam int unsigned CNT_W = $clog2(RING_TIMEOUT_SEC + 1);
   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [1:0]  MAX_CNT  = 2'(MAX_SNOOZE);
   localparam logic [17:0] SNOOZE_W = 18'(SNOOZE_SEC);
   localparam logic [17:0] DAY_W    = 18'(DAY_SEC);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RING   = 2'b01,
      ST_SNOOZE = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             buzzer_q, buzzer_d;
   logic [1:0]       snooze_cnt_q, snooze_cnt_d;
   logic [16:0]      compare_time_q, compare_time_d;
   logic             compare_en_q, compare_en_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic             match_q;
   logic             match_rise;
   logic [17:0]      snooze_sum;
   logic [16:0]      snooze_target;

   assign match_rise    = MATCH & ~match_q;
   assign snooze_sum    = {1'b0, CURRENT_TIME} + SNOOZE_W;
   // Sum is at most two days minus one, so a single subtraction wraps it.
   assign snooze_target = 17'((snooze_sum >= DAY_W) ? (snooze_sum - DAY_W) : snooze_sum);

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q        <= ST_IDLE;
         buzzer_q       <= 1'b0;
         snooze_cnt_q   <= 2'd0;
         compare_time_q <= 17'd0;
         compare_en_q   <= 1'b0;
         ring_cnt_q     <= '0;
         match_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         buzzer_q       <= buzzer_d;
         snooze_cnt_q   <= snooze_cnt_d;
         compare_time_q <= compare_time_d;
         compare_en_q   <= compare_en_d;
         ring_cnt_q     <= ring_cnt_d;
         match_q        <= MATCH;
      end
   end

   always_comb begin
      state_d        = state_q;
      buzzer_d       = buzzer_q;
      snooze_cnt_d   = snooze_cnt_q;
      compare_time_d = compare_time_q;
      compare_en_d   = compare_en_q;
      ring_cnt_d     = ring_cnt_q;

      case (state_q)
         ST_IDLE: begin
            compare_time_d = ALARM_TIME;
            compare_en_d   = ALARM_ENABLE;
            snooze_cnt_d   = 2'd0;
            buzzer_d       = 1'b0;
            ring_cnt_d     = '0;
            if (match_rise && ALARM_ENABLE) begin
               state_d      = ST_RING;
               buzzer_d     = 1'b1;
               compare_en_d = 1'b0;
            end
         end
         ST_RING: begin
            compare_en_d = 1'b0;
`ifdef BUZZER_BEEP_EN
            buzzer_d = TICK_1HZ ? ~buzzer_q : buzzer_q;
`else
            buzzer_d = 1'b1;
`endif
            if (TICK_1HZ) ring_cnt_d = ring_cnt_q + CNT_W'(1);
            if (STOP) begin
               state_d  = ST_IDLE;
               buzzer_d = 1'b0;
            end else if (SNOOZE && (snooze_cnt_q < MAX_CNT)) begin
               state_d        = ST_SNOOZE;
               buzzer_d       = 1'b0;
               compare_en_d   = 1'b1;
               compare_time_d = snooze_target;
               snooze_cnt_d   = snooze_cnt_q + 2'd1;
            end else if (TICK_1HZ && (ring_cnt_q == RING_LAST)) begin
               state_d  = ST_IDLE;
               buzzer_d = 1'b0;
            end
         end
         ST_SNOOZE: begin
            buzzer_d     = 1'b0;
            compare_en_d = 1'b1;
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (match_rise) begin
               state_d      = ST_RING;
               buzzer_d     = 1'b1;
               compare_en_d = 1'b0;
               ring_cnt_d   = '0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            buzzer_d     = 1'b0;
            compare_en_d = 1'b0;
         end
      endcase

      // Disabling the alarm overrides every other event.
      if (!ALARM_ENABLE) begin
         state_d      = ST_IDLE;
         buzzer_d     = 1'b0;
         snooze_cnt_d = 2'd0;
         compare_en_d = 1'b0;
      end
   end

   assign COMPARE_TIME = compare_time_q;
   assign COMPARE_EN   = compare_en_q;
   assign BUZZER       = buzzer_q;
   assign RING_STATE   = state_q;
   assign SNOOZE_CNT   = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: ring, snooze, wrap, snooze limit, timeout, keys, reset.
module tb_alarm_ring_ctrl;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        TICK_1HZ;
   logic        ALARM_ENABLE;
   logic [16:0] ALARM_TIME;
   logic [16:0] CURRENT_TIME;
   logic        MATCH;
   logic        STOP;
   logic        SNOOZE;
   logic [16:0] COMPARE_TIME;
   logic        COMPARE_EN;
   logic        BUZZER;
   logic [1:0]  RING_STATE;
   logic [1:0]  SNOOZE_CNT;

   int checks   = 0;
   int failures = 0;

   alarm_ring_ctrl dut (
      .CLK          (CLK),
      .RESETN       (RESETN),
      .TICK_1HZ     (TICK_1HZ),
      .ALARM_ENABLE (ALARM_ENABLE),
      .ALARM_TIME   (ALARM_TIME),
      .CURRENT_TIME (CURRENT_TIME),
      .MATCH        (MATCH),
      .STOP         (STOP),
      .SNOOZE       (SNOOZE),
      .COMPARE_TIME (COMPARE_TIME),
      .COMPARE_EN   (COMPARE_EN),
      .BUZZER       (BUZZER),
      .RING_STATE   (RING_STATE),
      .SNOOZE_CNT   (SNOOZE_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_snooze();
      SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
   endtask

   // Create a fresh MATCH rising edge at the comparator input.
   task automatic match_rise();
      MATCH = 1'b0; step(); MATCH = 1'b1; step(); MATCH = 1'b0;
   endtask

   initial begin
      RESETN = 1'b0; TICK_1HZ = 1'b0; ALARM_ENABLE = 1'b0;
      ALARM_TIME = 17'd0; CURRENT_TIME = 17'd0;
      MATCH = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
      step(); step();
      check("rst_buzzer", 32'(BUZZER), 0);
      check("rst_state", 32'(RING_STATE), 0);
      check("rst_cnt", 32'(SNOOZE_CNT), 0);
      check("rst_ctime", 32'(COMPARE_TIME), 0);
      check("rst_cen", 32'(COMPARE_EN), 0);

      RESETN = 1'b1; ALARM_ENABLE = 1'b1; ALARM_TIME = 17'd25200; CURRENT_TIME = 17'd25199;
      step();
      check("idle_ctime", 32'(COMPARE_TIME), 25200);
      check("idle_cen", 32'(COMPARE_EN), 1);

      // 1: match rise rings on the next edge
      CURRENT_TIME = 17'd25200; MATCH = 1'b1;
      step();
      check("t1_buzzer", 32'(BUZZER), 1);
      check("t1_state", 32'(RING_STATE), 1);
      check("t1_cen", 32'(COMPARE_EN), 0);
      MATCH = 1'b0; step();

      // 2: snooze and re-ring
      CURRENT_TIME = 17'd25205;
      pulse_snooze();
      check("t2_ctime", 32'(COMPARE_TIME), 25505);
      check("t2_state", 32'(RING_STATE), 2);
      check("t2_cnt", 32'(SNOOZE_CNT), 1);
      check("t2_buzzer", 32'(BUZZER), 0);
      check("t2_cen", 32'(COMPARE_EN), 1);
      CURRENT_TIME = 17'd25505; MATCH = 1'b1; step();
      check("t2_rering", 32'(RING_STATE), 1);
      check("t2_rebuzz", 32'(BUZZER), 1);
      MATCH = 1'b0; step();

      // 3: target wraps past midnight
      CURRENT_TIME = 17'd86300;
      pulse_snooze();
      check("t3_wrap", 32'(COMPARE_TIME), 200);
      check("t3_cnt", 32'(SNOOZE_CNT), 2);
      match_rise();
      check("t3_rering", 32'(RING_STATE), 1);

      // 4: third snooze, then a fourth is ignored
      CURRENT_TIME = 17'd1000;
      pulse_snooze();
      check("t4_ctime", 32'(COMPARE_TIME), 1300);
      check("t4_cnt3", 32'(SNOOZE_CNT), 3);
      match_rise();
      check("t4_rering", 32'(RING_STATE), 1);
      pulse_snooze();
      check("t4_ignored_state", 32'(RING_STATE), 1);
      check("t4_ignored_cnt", 32'(SNOOZE_CNT), 3);
      check("t4_ignored_buzz", 32'(BUZZER), 1);

      // 6a: STOP wins over SNOOZE
      STOP = 1'b1; SNOOZE = 1'b1; step(); STOP = 1'b0; SNOOZE = 1'b0;
      check("t6_state", 32'(RING_STATE), 0);
      check("t6_buzzer", 32'(BUZZER), 0);
      step();
      check("t6_cnt", 32'(SNOOZE_CNT), 0);
      check("t6_ctime", 32'(COMPARE_TIME), 25200);
      check("t6_cen", 32'(COMPARE_EN), 1);

      // 5: timeout with MATCH held high
      MATCH = 1'b0; step(); MATCH = 1'b1; step();
      check("t5_ring", 32'(RING_STATE), 1);
      for (int i = 0; i < 59; i++) begin
         TICK_1HZ = 1'b1; step(); TICK_1HZ = 1'b0; step();
      end
      check("t5_59_state", 32'(RING_STATE), 1);
`ifdef BUZZER_BEEP_EN
      check("t5_59_buzz", 32'(BUZZER), 0);
`else
      check("t5_59_buzz", 32'(BUZZER), 1);
`endif
      TICK_1HZ = 1'b1; step(); TICK_1HZ = 1'b0;
      check("t5_60_state", 32'(RING_STATE), 0);
      check("t5_60_buzz", 32'(BUZZER), 0);
      step(); step(); step();
      check("t5_noretrig", 32'(RING_STATE), 0);
      check("t5_noretrig_buzz", 32'(BUZZER), 0);

      // ALARM_ENABLE low forces IDLE from SNOOZE
      match_rise();
      CURRENT_TIME = 17'd5000;
      pulse_snooze();
      check("en_snz_cnt", 32'(SNOOZE_CNT), 1);
      ALARM_ENABLE = 1'b0; step();
      check("en_off_state", 32'(RING_STATE), 0);
      check("en_off_cnt", 32'(SNOOZE_CNT), 0);
      check("en_off_cen", 32'(COMPARE_EN), 0);
      match_rise();
      check("en_off_noring", 32'(RING_STATE), 0);

      // 6b: reset mid-RING
      ALARM_ENABLE = 1'b1; step();
      match_rise();
      pulse_snooze();
      match_rise();
      check("r_ring", 32'(RING_STATE), 1);
      check("r_cnt", 32'(SNOOZE_CNT), 1);
      RESETN = 1'b0; step();
      check("r_buzzer", 32'(BUZZER), 0);
      check("r_state", 32'(RING_STATE), 0);
      check("r_cnt0", 32'(SNOOZE_CNT), 0);
      check("r_ctime", 32'(COMPARE_TIME), 0);
      check("r_cen", 32'(COMPARE_EN), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
